// File: rtl/muldiv_iter.sv
// Iterative 32-bit multiply/divide unit answering the EX-stage start/ready stall handshake.
// 32-step shift-add multiply or restoring divide; registered {hi, lo} result with a ready pulse.
module muldiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic [31:0] shreg;     // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [31:0] divisor;
    logic [63:0] mcand;
    logic [63:0] acc;
    logic [31:0] rem;

    logic        sign1;
    logic        sign2;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [63:0] acc_step;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [63:0] prod_fin;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;

    assign sign1 = op_i[0] & opdata1_i[31];
    assign sign2 = op_i[0] & opdata2_i[31];
    assign abs1  = sign1 ? -opdata1_i : opdata1_i;
    assign abs2  = sign2 ? -opdata2_i : opdata2_i;

    assign acc_step = shreg[0] ? acc + mcand : acc;

    // 33-bit trial remainder so the shifted-out MSB is never lost
    assign shifted  = {rem, shreg[31]};
    assign fits     = shifted >= {1'b0, divisor};
    assign diff     = shifted[31:0] - divisor;
    assign rem_step = fits ? diff : shifted[31:0];
    assign quo_step = {shreg[30:0], fits};

    assign prod_fin = neg_res ? -acc_step : acc_step;
    assign quo_fin  = neg_res ? -quo_step : quo_step;
    assign rem_fin  = neg_rem ? -rem_step : rem_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= 6'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            shreg    <= 32'd0;
            divisor  <= 32'd0;
            mcand    <= 64'd0;
            acc      <= 64'd0;
            rem      <= 32'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            if (annul_i) begin
                state  <= StIdle;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (start_i) begin
                            is_div  <= op_i[1];
                            neg_res <= sign1 ^ sign2;
                            neg_rem <= sign1;
                            cnt     <= 6'd0;
                            shreg   <= op_i[1] ? abs1 : abs2;
                            divisor <= abs2;
                            mcand   <= {32'd0, abs1};
                            acc     <= 64'd0;
                            rem     <= 32'd0;
                            busy_o  <= 1'b1;
                            if (op_i[1] && (opdata2_i == 32'd0)) begin
                                result_o <= {opdata1_i, 32'hFFFF_FFFF};
                                ready_o  <= 1'b1;
                                state    <= StDone;
                            end else begin
                                state <= StRun;
                            end
                        end
                    end
                    StRun: begin
                        cnt <= cnt + 6'd1;
                        if (is_div) begin
                            rem   <= rem_step;
                            shreg <= quo_step;
                        end else begin
                            acc   <= acc_step;
                            mcand <= {mcand[62:0], 1'b0};
                            shreg <= {1'b0, shreg[31:1]};
                        end
                        if (cnt == 6'd31) begin
                            result_o <= is_div ? {rem_fin, quo_fin} : prod_fin;
                            ready_o  <= 1'b1;
                            state    <= StDone;
                        end
                    end
                    StDone: begin
                        state  <= StIdle;
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state  <= StIdle;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: stimulus pushes expected results and ready cycles,
// a negedge monitor pops and compares whenever ready_o is seen.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    typedef struct {
        logic [63:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    muldiv_iter dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .annul_i   (annul),
        .op_i      (op),
        .opdata1_i (a),
        .opdata2_i (b),
        .result_o  (result),
        .ready_o   (ready),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    // Edge count; after the edge that samples start, ready is due 32 edges later (0 for div-by-zero)
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: ready=1 at edge %0d, required 0", cyc);
            end else begin
                e = sb.pop_front();
                check64({e.name, "_result"}, result, e.res);
                check64({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] r, input bit dbz,
                         input bit push, input bit hold, output int t);
        exp_t e;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        if (!hold) start = 1'b0;
        if (push) begin
            e.res  = r;
            e.due  = dbz ? t : t + 32;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results still pending, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_result", result, 64'd0);
        check64("reset_ready", 64'(ready), 64'd0);
        check64("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue("muls_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 1, 0, t);
        wait_done();
        issue("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1, 0, t);
        wait_done();
        issue("mulu_shift", 2'b00, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780, 0, 1, 0, t);
        wait_done();
        issue("divs_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1, 0, t);
        wait_done();
        issue("divs_7byneg2", 2'b11, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, 1, 0, t);
        wait_done();
        issue("divs_overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000,
              0, 1, 0, t);
        wait_done();
        issue("divu_100by7", 2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0, 1, 0, t);
        wait_done();
        issue("divu_by0", 2'b10, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 1, 1, 0, t);
        wait_done();

        // Annul in cycle T+10: no ready, result keeps the div-by-zero value
        issue("annulled", 2'b10, 32'd100, 32'd7, 64'd0, 0, 0, 0, t);
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        check64("annul_busy", 64'(busy), 64'd0);
        check64("annul_ready", 64'(ready), 64'd0);
        check64("annul_result_held", result, 64'h0000_1234_FFFF_FFFF);
        @(posedge clk);
        #1;
        issue("after_annul", 2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0, 1, 0, t);
        wait_done();

        // Reset mid-RUN discards the operation
        issue("reset_run", 2'b01, 32'd5, 32'd5, 64'd0, 0, 0, 0, t);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check64("midrun_rst_result", result, 64'd0);
        check64("midrun_rst_ready", 64'(ready), 64'd0);
        check64("midrun_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // start held high: second operation sampled 34 edges after the first
        issue("hold_first", 2'b00, 32'd3, 32'd4, 64'd12, 0, 1, 1, t);
        repeat (33) @(posedge clk);
        #1;
        check64("hold_idle_gap_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check64("hold_restart_busy", 64'(busy), 64'd1);
        start = 1'b0;
        begin
            exp_t e;
            e.res  = 64'd12;
            e.due  = cyc + 32;
            e.name = "hold_second";
            sb.push_back(e);
        end
        wait_done();
        repeat (5) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Iterative 32-bit multiply/divide responder for the EX stage: accepts a start request with two operands and an op code, runs a 32-step shift-add multiply or restoring divide, and returns a 64-bit {hi, lo} result with a one-cycle ready pulse. It is the responding end of the EX start/ready stall handshake. EX holds start and operands stable and raises its stall request until ready is seen; the result then goes straight into the HI/LO write path.

## Interface
- No parameters; datapath fixed at 32-bit operands, 64-bit result.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start_i  input  1  request; sampled only in IDLE.
- annul_i  input  1  cancel; aborts any operation in progress.
- op_i  input  2  bit1: 1=divide, 0=multiply; bit0: 1=signed, 0=unsigned. Sampled with start_i.
- opdata1_i  input  32  multiplicand / dividend.
- opdata2_i  input  32  multiplier / divisor.
- result_o  output  64  mul: {product[63:32], product[31:0]}; div: {remainder, quotient}.
- ready_o  output  1  one-cycle pulse; result_o is valid in that cycle.
- busy_o  output  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start_i=1, annul_i=0: latch op_i. Latch |opdata1_i| and |opdata2_i| when signed; raw values when unsigned. Record the result sign flags, clear the 6-bit counter, go to RUN.
- IDLE, divide with opdata2_i==0: skip RUN and go directly to DONE. result_o = {opdata1_i, 32'hFFFF_FFFF}.
- RUN multiply: 64-bit accumulator, one multiplier bit per cycle, LSB first. Add the left-shifted multiplicand when the bit is 1.
- RUN divide: restoring division, one quotient bit per cycle, MSB first. Use a 33-bit partial remainder so there is no carry loss.
- After 32 RUN cycles (counter 31), apply sign correction while registering result_o, then go to DONE.
- Signed multiply: negate the 64-bit product when the operand signs differ.
- Signed divide: negate the quotient when the signs differ. Negate the remainder when the dividend is negative.
- 0x80000000 / -1 (signed) yields quotient 0x80000000, remainder 0. No trap.
- DONE: ready_o=1 for exactly one cycle, then IDLE unconditionally.
- start_i is ignored outside IDLE. A start seen in the IDLE cycle after DONE begins a new operation; the requester is responsible for dropping start.
- annul_i=1 in any state: next state IDLE, ready_o=0 next cycle, result_o unchanged.
- annul_i=1 together with start_i in IDLE: annul wins and nothing is started.
- result_o holds its last value until the next completed or div-by-zero operation.
- Reset values: state IDLE, result_o=0, ready_o=0, busy_o=0, counter=0, internal registers 0.
- Reset asserted mid-RUN: same as the reset values, in-flight result discarded.

## Timing
- Start sampled at edge T (IDLE). RUN occupies cycles T+1..T+32. DONE and ready_o=1 in cycle T+33, IDLE in T+34.
- Divide-by-zero: ready_o=1 in cycle T+1.
- ready_o and result_o are registered, not combinational from inputs. This guarantees EX sees a stable result in the ready cycle.
- Back-to-back: the earliest next start is sampled in cycle T+34, giving a minimum issue interval of 34 cycles.

## Test plan
- Signed multiply: op=01, -3 × 5 (0xFFFFFFFD, 0x00000005) -> ready in T+33, result_o=0xFFFFFFFF_FFFFFFF1. ready_o high exactly 1 cycle.
- Unsigned multiply: op=00, 0xFFFFFFFF × 0xFFFFFFFF -> result_o=0xFFFFFFFE_00000001.
- Signed divide: op=11, -7 / 2 -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3). Also 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000.
- Unsigned divide and div-by-zero: op=10, 100 / 7 -> 0x00000002_0000000E at T+33. Then 0x1234 / 0 -> 0x00001234_FFFFFFFF with ready at T+1.
- Annul and restart: start divu 100/7, assert annul_i at T+10 -> busy_o=0 at T+11, no ready pulse, result_o unchanged. A new start at T+12 completes normally at T+45.
- Reset and protocol: assert rst mid-RUN -> all outputs 0 next cycle. Also hold start_i high through an entire operation -> exactly one ready pulse, and a new operation begins at T+34.
